stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Stopwatch controller for the timing project: owns the millisecond prescaler and sequences it with start/stop, lap and clear commands. It holds a minutes:seconds:milliseconds count and presents either the live count or a frozen lap value to the display driver. It replaces the free-running divided clock with a single-cycle tick enable, so the whole design stays on one clock.

## Interface
- TICK_DIV, 50000: system clocks per millisecond tick (1 ms at 50 MHz); must be ≥ 2.
- PRE_W, 16: prescaler width; must satisfy 2^PRE_W ≥ TICK_DIV.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_stop  in  1  one-cycle pulse; toggles run/pause.
- lap  in  1  one-cycle pulse; freezes or releases the display.
- clear  in  1  one-cycle pulse; returns to idle and zeroes everything.
- disp_min  out  6  displayed minutes, 0–59.
- disp_sec  out  6  displayed seconds, 0–59.
- disp_ms  out  10  displayed milliseconds, 0–999.
- running  out  1  high in RUN.
- lap_active  out  1  high while the display is frozen.
- ovf  out  1  sticky; set when the count wraps past 59:59.999.

## Operation
- States:
  - IDLE: counts zero, prescaler zero.
  - RUN: prescaler advances.
  - PAUSE: prescaler and counts hold.
- Transitions:
  - IDLE --start_stop--> RUN.
  - RUN --start_stop--> PAUSE.
  - PAUSE --start_stop--> RUN.
  - Any state --clear--> IDLE.
  - lap does not change state.
- Priority in one cycle: clear > start_stop > lap. Clear also zeroes the counts, lap register, lap_active and ovf.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick = (state==RUN && pre==TICK_DIV-1). On tick, pre→0.
  - Holds its value in PAUSE, so resume keeps the partial millisecond.
  - Zeroed on clear.
- Count chain on tick:
  - ms increments; 999→0 carries into sec.
  - sec 59→0 carries into min.
  - min 59→0 (full wrap 59:59.999→00:00.000) sets ovf. Counting continues.
- Lap:
  - lap pulse while lap_active=0 and state RUN or PAUSE: copy the current registered count (pre-increment value if tick fires the same cycle) into the lap register; set lap_active.
  - lap pulse while lap_active=1: clear lap_active.
  - lap pulse in IDLE: ignored.
  - Counting is unaffected by lap in all cases.
- Display mux: disp_* = lap_active ? lap register : live count.
- start_stop and tick in the same RUN cycle: the tick is counted, then the state becomes PAUSE.
- Widths: ms is 10-bit binary, min and sec are 6-bit binary. No BCD conversion in this block.

## Timing
- Every register resets asynchronously on rst_n low. Reset values:
  - state=IDLE, pre=0, all counts 0, lap register 0.
  - disp_*=0, running=0, lap_active=0, ovf=0.
- rst_n release is used synchronously. A reset mid-run abandons the count.
- All outputs are registered or driven directly from registers. No combinational path from inputs to outputs.
- start_stop sampled at edge E0 in IDLE:
  - running=1 after E0.
  - First ms increment visible after edge E0+TICK_DIV.
  - Thereafter one increment every TICK_DIV cycles.
- Pause at edge Ep with pre=k, resume at edge Er: the next increment appears at Er+(TICK_DIV-1-k)+1.
- lap_active and the frozen display values change at the edge that samples lap.
- clear: everything is zero one edge after it is sampled.

## Test plan
- Reset, then start, with TICK_DIV=4: ms reads 1 at 4 cycles after start and 5 after 20 cycles; running=1.
- Pause/resume fraction: pause when pre=2; hold 50 cycles (count frozen); resume: next increment 2 cycles after resume.
- Lap:
  - Lap at 00:00.010 while running: display holds 0,0,10 for 40 cycles while the live count reaches 20.
  - Second lap pulse: display jumps to the live value and lap_active=0.
- Rollover: preload the count near 59:59.998 via run time (TICK_DIV=2); after 2 ticks display is 0,0,0 and ovf=1. ovf stays 1 until clear.
- Simultaneous events:
  - clear+start_stop in RUN → IDLE, counts 0, running=0.
  - start_stop on a tick cycle → count incremented, running=0.
- Async reset mid-run with lap_active=1 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: millisecond prescaler, min:sec:ms count chain,
// run/pause/idle sequencing and a lap freeze register for the display.
//
// Handshake: start_stop, lap and clear are single-cycle command pulses,
// sampled on every rising edge with no ready/acknowledge. A pulse is acted on
// at the edge that samples it. Priority within one cycle: clear, start_stop, lap.
// All outputs come from registers (disp_* is a register-to-register mux),
// so no input reaches an output combinationally.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000,  // system clocks per millisecond tick, >= 2
  parameter int PRE_W    = 16      // prescaler width, 2**PRE_W >= TICK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [5:0] disp_min,
  output logic [5:0] disp_sec,
  output logic [9:0] disp_ms,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [9:0]       ms_q, ms_d;
  logic [5:0]       lap_min_q, lap_min_d;
  logic [5:0]       lap_sec_q, lap_sec_d;
  logic [9:0]       lap_ms_q, lap_ms_d;
  logic             lap_active_q, lap_active_d;
  logic             ovf_q, ovf_d;

  // FSM decodes used by the datapath
  logic tick;
  logic lap_allowed;

  // State and datapath registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pre_q        <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      ms_q         <= '0;
      lap_min_q    <= '0;
      lap_sec_q    <= '0;
      lap_ms_q     <= '0;
      lap_active_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      ms_q         <= ms_d;
      lap_min_q    <= lap_min_d;
      lap_sec_q    <= lap_sec_d;
      lap_ms_q     <= lap_ms_d;
      lap_active_q <= lap_active_d;
      ovf_q        <= ovf_d;
    end
  end

  // Next-state logic: clear wins, otherwise start_stop toggles run/pause
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (start_stop) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: run flag, millisecond tick enable, lap permission
  always_comb begin
    running     = (state_q == S_RUN);
    tick        = (state_q == S_RUN) && (pre_q == PRE_MAX);
    lap_allowed = (state_q != S_IDLE);
  end

  // Prescaler advances only in RUN; PAUSE keeps the partial millisecond
  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (state_q == S_RUN) begin
      pre_d = tick ? '0 : pre_q + PRE_ONE;
    end
  end

  // Count chain ms -> sec -> min; a full wrap sets the sticky overflow
  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    ms_d  = ms_q;
    ovf_d = ovf_q;
    if (clear) begin
      min_d = '0;
      sec_d = '0;
      ms_d  = '0;
      ovf_d = 1'b0;
    end else if (tick) begin
      if (ms_q == 10'd999) begin
        ms_d = '0;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d = '0;
            ovf_d = 1'b1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        ms_d = ms_q + 10'd1;
      end
    end
  end

  // Lap register: capture the pre-increment count, or release the freeze
  always_comb begin
    lap_min_d    = lap_min_q;
    lap_sec_d    = lap_sec_q;
    lap_ms_d     = lap_ms_q;
    lap_active_d = lap_active_q;
    if (clear) begin
      lap_min_d    = '0;
      lap_sec_d    = '0;
      lap_ms_d     = '0;
      lap_active_d = 1'b0;
    end else if (lap) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else if (lap_allowed) begin
        lap_min_d    = min_q;
        lap_sec_d    = sec_q;
        lap_ms_d     = ms_q;
        lap_active_d = 1'b1;
      end
    end
  end

  // Display mux between frozen lap value and live count
  always_comb begin
    lap_active = lap_active_q;
    ovf        = ovf_q;
    disp_min   = lap_active_q ? lap_min_q : min_q;
    disp_sec   = lap_active_q ? lap_sec_q : sec_q;
    disp_ms    = lap_active_q ? lap_ms_q  : ms_q;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4. Expected output words
// {running, lap_active, ovf, min, sec, ms} are queued at each stimulus step
// and popped when the outputs are sampled at the following falling edge.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int PRE_W    = 4;

  logic       clk;
  logic       rst_n;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [5:0] disp_min;
  logic [5:0] disp_sec;
  logic [9:0] disp_ms;
  logic       running;
  logic       lap_active;
  logic       ovf;

  int total;
  int bad;

  logic [24:0] exp_q[$];

  stopwatch_ctrl #(
    .TICK_DIV(TICK_DIV),
    .PRE_W   (PRE_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_stop(start_stop),
    .lap       (lap),
    .clear     (clear),
    .disp_min  (disp_min),
    .disp_sec  (disp_sec),
    .disp_ms   (disp_ms),
    .running   (running),
    .lap_active(lap_active),
    .ovf       (ovf)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, ending on a falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle command pulse; called on a falling edge, sampled by the next rise
  task automatic pulse(input bit ss, input bit lp, input bit cl);
    start_stop = ss;
    lap        = lp;
    clear      = cl;
    @(negedge clk);
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
  endtask

  // Queue one expected output word
  task automatic expect_out(input bit r, input bit l, input bit o,
                            input int mn, input int sc, input int ms);
    exp_q.push_back({r, l, o, 6'(mn), 6'(sc), 10'(ms)});
  endtask

  // Pop the oldest expectation and compare against the sampled outputs
  task automatic check(input string tag);
    logic [24:0] exp_w;
    logic [24:0] obs_w;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no expected value queued", tag);
      return;
    end
    exp_w = exp_q.pop_front();
    obs_w = {running, lap_active, ovf, disp_min, disp_sec, disp_ms};
    total++;
    assert (obs_w === exp_w) else begin
      bad++;
      $error("FAIL %s: got run=%0b lap=%0b ovf=%0b %0d:%0d.%0d expected run=%0b lap=%0b ovf=%0b %0d:%0d.%0d",
             tag, obs_w[24], obs_w[23], obs_w[22], obs_w[21:16], obs_w[15:10], obs_w[9:0],
             exp_w[24], exp_w[23], exp_w[22], exp_w[21:16], exp_w[15:10], exp_w[9:0]);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;

    // Reset state
    #1;
    expect_out(0, 0, 0, 0, 0, 0);
    check("reset_asserted");
    step(2);
    rst_n = 1'b1;
    step(1);
    expect_out(0, 0, 0, 0, 0, 0);
    check("reset_released");

    // Start: first increment TICK_DIV edges after the start edge
    pulse(1, 0, 0);
    expect_out(1, 0, 0, 0, 0, 0);
    check("start_running");
    step(3);
    expect_out(1, 0, 0, 0, 0, 0);
    check("before_first_tick");
    step(1);
    expect_out(1, 0, 0, 0, 0, 1);
    check("first_tick");
    step(16);
    expect_out(1, 0, 0, 0, 0, 5);
    check("after_20_cycles");

    // Pause with the prescaler held at 2, then resume
    step(1);
    pulse(1, 0, 0);
    expect_out(0, 0, 0, 0, 0, 5);
    check("paused");
    step(50);
    expect_out(0, 0, 0, 0, 0, 5);
    check("pause_hold_50");
    pulse(1, 0, 0);
    expect_out(1, 0, 0, 0, 0, 5);
    check("resumed");
    step(1);
    expect_out(1, 0, 0, 0, 0, 5);
    check("resume_plus1");
    step(1);
    expect_out(1, 0, 0, 0, 0, 6);
    check("resume_plus2_tick");

    // Lap at 00:00.010 while running, held for 40 cycles
    step(16);
    expect_out(1, 0, 0, 0, 0, 10);
    check("live_10");
    pulse(0, 1, 0);
    expect_out(1, 1, 0, 0, 0, 10);
    check("lap_freeze");
    step(40);
    expect_out(1, 1, 0, 0, 0, 10);
    check("lap_hold_40");
    pulse(0, 1, 0);
    expect_out(1, 0, 0, 0, 0, 20);
    check("lap_release_live");

    // Lap on a tick cycle captures the pre-increment value
    step(1);
    pulse(0, 1, 0);
    expect_out(1, 1, 0, 0, 0, 20);
    check("lap_on_tick");
    pulse(0, 1, 0);
    expect_out(1, 0, 0, 0, 0, 21);
    check("lap_on_tick_live");

    // start_stop on a tick cycle: tick counted, then PAUSE
    step(2);
    pulse(1, 0, 0);
    expect_out(0, 0, 0, 0, 0, 22);
    check("pause_on_tick");

    // Seconds carry into minutes, no overflow
    force dut.min_q = 6'd0;
    force dut.sec_q = 6'd59;
    force dut.ms_q  = 10'd999;
    step(1);
    release dut.min_q;
    release dut.sec_q;
    release dut.ms_q;
    expect_out(0, 0, 0, 0, 59, 999);
    check("preload_0_59_999");
    pulse(1, 0, 0);
    step(3);
    expect_out(1, 0, 0, 0, 59, 999);
    check("before_sec_carry");
    step(1);
    expect_out(1, 0, 0, 1, 0, 0);
    check("sec_carry_to_min");

    // Full wrap past 59:59.999 sets sticky overflow
    pulse(1, 0, 0);
    force dut.min_q = 6'd59;
    force dut.sec_q = 6'd59;
    force dut.ms_q  = 10'd998;
    step(1);
    release dut.min_q;
    release dut.sec_q;
    release dut.ms_q;
    expect_out(0, 0, 0, 59, 59, 998);
    check("preload_59_59_998");
    pulse(1, 0, 0);
    step(3);
    expect_out(1, 0, 0, 59, 59, 999);
    check("wrap_minus1");
    step(4);
    expect_out(1, 0, 1, 0, 0, 0);
    check("wrap_ovf_set");
    step(8);
    expect_out(1, 0, 1, 0, 0, 2);
    check("ovf_sticky");

    // clear together with start_stop in RUN: clear wins
    pulse(1, 0, 1);
    expect_out(0, 0, 0, 0, 0, 0);
    check("clear_with_start");
    step(10);
    expect_out(0, 0, 0, 0, 0, 0);
    check("idle_hold");

    // lap in IDLE is ignored
    pulse(0, 1, 0);
    expect_out(0, 0, 0, 0, 0, 0);
    check("lap_in_idle");

    // Async reset mid-run with lap active
    pulse(1, 0, 0);
    step(9);
    pulse(0, 1, 0);
    expect_out(1, 1, 0, 0, 0, 2);
    check("lap_before_reset");
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(0, 0, 0, 0, 0, 0);
    check("async_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
